ctlr_emulator: RTL and testbench

- Virtual NES standard-controller pair feeding the serial ctlr_data_p1/ctlr_data_p2 inputs of cpu_memory.
- Takes raw button levels from board switches or a host bridge and synchronizes and debounces them.
- Applies optional turbo to A/B and emulates the two 4021 shift registers.
- Responds to the $4016 strobe and the $4016/$4017 read pulses produced by cpu_memory.

---
 rtl/ctlr_emulator.sv | 135 +++++++++++++
 tb/tb_ctlr_emulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ctlr_emulator.sv
// Virtual NES controller pair: synchronizes, debounces and turbo-gates raw
// buttons, then emulates the two 4021 shift registers read via $4016/$4017.
module ctlr_emulator #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int TURBO_FRAMES    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clock_en,
    input  logic       stall,
    input  logic       vblank_nmi,
    input  logic [7:0] btn_p1_raw,
    input  logic [7:0] btn_p2_raw,
    input  logic [3:0] turbo_en,
    input  logic       ctlr_strobe,
    input  logic       ctlr_rd_p1,
    input  logic       ctlr_rd_p2,
    output logic       ctlr_data_p1,
    output logic       ctlr_data_p2,
    output logic [7:0] btn_p1_db,
    output logic [7:0] btn_p2_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(TURBO_FRAMES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(TURBO_FRAMES - 1);

    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    logic [15:0]   r_db;
    logic [CW-1:0] r_cnt [16];
    logic          r_vblank_q;
    logic [FW-1:0] r_frame_cnt;
    logic          r_turbo_phase;
    logic [7:0]    r_sr_p1;
    logic [7:0]    r_sr_p2;

    logic          w_run;
    logic          w_tick;
    logic          w_shift_en;
    logic [7:0]    w_eff_p1;
    logic [7:0]    w_eff_p2;

    assign w_run      = ~stall;
    assign w_tick     = vblank_nmi & ~r_vblank_q;
    assign w_shift_en = clock_en & ~stall;

    // A/B are gated by the turbo phase only when their enable is set
    assign w_eff_p1 = {r_db[7:2],
                       r_db[1] & (turbo_en[1] ? r_turbo_phase : 1'b1),
                       r_db[0] & (turbo_en[0] ? r_turbo_phase : 1'b1)};
    assign w_eff_p2 = {r_db[15:10],
                       r_db[9] & (turbo_en[3] ? r_turbo_phase : 1'b1),
                       r_db[8] & (turbo_en[2] ? r_turbo_phase : 1'b1)};

    assign ctlr_data_p1 = r_sr_p1[0];
    assign ctlr_data_p2 = r_sr_p2[0];
    assign btn_p1_db    = r_db[7:0];
    assign btn_p2_db    = r_db[15:8];

    // Two-flop synchronizer; keeps running through stall
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_p2_raw, btn_p1_raw};
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: flip after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_db <= '0;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_run) begin
            for (int i = 0; i < 16; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == DB_LAST) begin
                        r_db[i]  <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Frame tick on vblank rising edge drives the turbo phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_q    <= 1'b0;
            r_frame_cnt   <= '0;
            r_turbo_phase <= 1'b0;
        end else if (w_run) begin
            r_vblank_q <= vblank_nmi;
            if (w_tick) begin
                if (r_frame_cnt == FR_LAST) begin
                    r_frame_cnt   <= '0;
                    r_turbo_phase <= ~r_turbo_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // 4021 emulation: strobe reloads, read shifts in ones from the top
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sr_p1 <= 8'hFF;
            r_sr_p2 <= 8'hFF;
        end else if (w_shift_en) begin
            if (ctlr_strobe) begin
                r_sr_p1 <= w_eff_p1;
                r_sr_p2 <= w_eff_p2;
            end else begin
                if (ctlr_rd_p1) begin
                    r_sr_p1 <= {1'b1, r_sr_p1[7:1]};
                end
                if (ctlr_rd_p2) begin
                    r_sr_p2 <= {1'b1, r_sr_p2[7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_ctlr_emulator.sv
// Directed bench for ctlr_emulator: debounce timing, 4021 read order,
// strobe reload, turbo phase, stall freeze and asynchronous reset.
module tb_ctlr_emulator;

    localparam int DB = 16;
    localparam int TF = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clock_en = 1'b0;
    logic       stall = 1'b0;
    logic       vblank_nmi = 1'b0;
    logic [7:0] btn_p1_raw = '0;
    logic [7:0] btn_p2_raw = '0;
    logic [3:0] turbo_en = '0;
    logic       ctlr_strobe = 1'b0;
    logic       ctlr_rd_p1 = 1'b0;
    logic       ctlr_rd_p2 = 1'b0;
    logic       ctlr_data_p1;
    logic       ctlr_data_p2;
    logic [7:0] btn_p1_db;
    logic [7:0] btn_p2_db;

    int n_tests = 0;
    int n_fail  = 0;

    ctlr_emulator #(
        .DEBOUNCE_CYCLES(DB),
        .TURBO_FRAMES   (TF)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clock_en    (clock_en),
        .stall       (stall),
        .vblank_nmi  (vblank_nmi),
        .btn_p1_raw  (btn_p1_raw),
        .btn_p2_raw  (btn_p2_raw),
        .turbo_en    (turbo_en),
        .ctlr_strobe (ctlr_strobe),
        .ctlr_rd_p1  (ctlr_rd_p1),
        .ctlr_rd_p2  (ctlr_rd_p2),
        .ctlr_data_p1(ctlr_data_p1),
        .ctlr_data_p2(ctlr_data_p2),
        .btn_p1_db   (btn_p1_db),
        .btn_p2_db   (btn_p2_db)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe_pulse();
        ctlr_strobe = 1'b1;
        clock_en    = 1'b1;
        cyc();
        ctlr_strobe = 1'b0;
        clock_en    = 1'b0;
    endtask

    task automatic read_p1(output logic b);
        b          = ctlr_data_p1;
        ctlr_rd_p1 = 1'b1;
        clock_en   = 1'b1;
        cyc();
        ctlr_rd_p1 = 1'b0;
        clock_en   = 1'b0;
    endtask

    task automatic vblank_pulse();
        vblank_nmi = 1'b1;
        cyc();
        cyc();
        vblank_nmi = 1'b0;
        cyc();
        cyc();
    endtask

    logic       b;
    logic [9:0] exp_bits;
    logic [7:0] exp_turbo;

    initial begin
        exp_bits  = 10'b11_0000_1001;
        exp_turbo = 8'b1100_1100;

        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        check("rst_d1", {7'd0, ctlr_data_p1}, 8'd1);
        check("rst_d2", {7'd0, ctlr_data_p2}, 8'd1);
        check("rst_db1", btn_p1_db, 8'h00);
        check("rst_db2", btn_p2_db, 8'h00);

        // Button pattern and full read-out order
        btn_p1_raw = 8'h09;
        btn_p2_raw = 8'h01;
        repeat (DB + 6) cyc();
        check("db1_09", btn_p1_db, 8'h09);
        check("db2_01", btn_p2_db, 8'h01);
        strobe_pulse();
        for (int i = 0; i < 10; i++) begin
            read_p1(b);
            check($sformatf("rd_p1_%0d", i), {7'd0, b},
                  {7'd0, exp_bits[i]});
        end
        check("p2_idle", {7'd0, ctlr_data_p2}, 8'd1);

        // Glitch shorter than the debounce window is ignored
        btn_p1_raw = 8'h0D;
        repeat (DB / 2) cyc();
        btn_p1_raw = 8'h09;
        repeat (DB + 6) cyc();
        check("glitch", btn_p1_db, 8'h09);

        // Held change flips exactly 2+DB clocks after the raw edge
        btn_p1_raw = 8'h0D;
        repeat (DB + 1) cyc();
        check("db_early", btn_p1_db, 8'h09);
        cyc();
        check("db_exact", btn_p1_db, 8'h0D);
        btn_p1_raw = 8'h09;
        repeat (DB + 6) cyc();
        check("db_back", btn_p1_db, 8'h09);

        // Strobe held: every read returns A
        ctlr_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read_p1(b);
            check($sformatf("strb_%0d", i), {7'd0, b}, 8'd1);
        end
        ctlr_strobe = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            read_p1(b);
            check($sformatf("pre_rl_%0d", i), {7'd0, b},
                  {7'd0, exp_bits[i]});
        end
        strobe_pulse();
        check("reload_a", {7'd0, ctlr_data_p1}, 8'd1);

        // Read pulse without clock_en is ignored
        ctlr_rd_p1 = 1'b1;
        cyc();
        ctlr_rd_p1 = 1'b0;
        check("no_ce", {7'd0, ctlr_data_p1}, 8'd1);

        // Simultaneous reads shift both players
        ctlr_rd_p1 = 1'b1;
        ctlr_rd_p2 = 1'b1;
        clock_en   = 1'b1;
        cyc();
        ctlr_rd_p1 = 1'b0;
        ctlr_rd_p2 = 1'b0;
        clock_en   = 1'b0;
        check("both_p1", {7'd0, ctlr_data_p1}, 8'd0);
        check("both_p2", {7'd0, ctlr_data_p2}, 8'd0);

        // Turbo on p1 A: latch, then frame tick
        turbo_en = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            strobe_pulse();
            check($sformatf("turbo_%0d", i), {7'd0, ctlr_data_p1},
                  {7'd0, exp_turbo[i]});
            vblank_pulse();
        end

        // Stall freezes shift register and turbo phase
        turbo_en = 4'b0000;
        strobe_pulse();
        read_p1(b);
        check("pre_stall", {7'd0, b}, 8'd1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) read_p1(b);
        vblank_pulse();
        vblank_pulse();
        check("stall_sr", {7'd0, ctlr_data_p1}, 8'd0);
        stall = 1'b0;
        cyc();
        read_p1(b);
        check("resume_b", {7'd0, b}, 8'd0);
        read_p1(b);
        check("resume_sel", {7'd0, b}, 8'd0);
        check("resume_st", {7'd0, ctlr_data_p1}, 8'd1);
        turbo_en = 4'b0001;
        strobe_pulse();
        check("stall_phase", {7'd0, ctlr_data_p1}, 8'd0);

        // Asynchronous reset mid-sequence
        turbo_en = 4'b0000;
        strobe_pulse();
        read_p1(b);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_d1", {7'd0, ctlr_data_p1}, 8'd1);
        check("arst_db1", btn_p1_db, 8'h00);
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
